// File: rtl/lcd_8080_tx.sv
`timescale 1ns/1ps
// lcd_8080_tx: write-only 8080-I 16-bit bus transmitter for an ILI9341 panel.
// Buffers {dcx, data} words in a FIFO, runs the panel hardware-reset sequence,
// and generates csx/wrx strobes (WR_LOW cycles low, WR_HIGH cycles high).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    word handshake; in_data (16b) + in_dcx travel together
//   hw_reset_req         one-cycle pulse: flush FIFO, abort write, restart panel reset
//   lcd_on_en / lcd_on   panel-on request, registered through
//   busy, fifo_level     status
//   res_n, csx, wrx, rdx, dcx, d   panel conduit (all registered)
module lcd_8080_tx #(
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned WR_LOW          = 2,
    parameter int unsigned WR_HIGH         = 2,
    parameter int unsigned RST_LOW_CYCLES  = 500,
    parameter int unsigned RST_WAIT_CYCLES = 6000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [15:0]                   in_data,
    input  logic                          in_dcx,
    input  logic                          hw_reset_req,
    input  logic                          lcd_on_en,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          res_n,
    output logic                          csx,
    output logic                          wrx,
    output logic                          rdx,
    output logic                          dcx,
    output logic [15:0]                   d,
    output logic                          lcd_on
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned LW      = AW + 1;
    localparam int unsigned RST_MAX = (RST_WAIT_CYCLES > RST_LOW_CYCLES) ? RST_WAIT_CYCLES : RST_LOW_CYCLES;
    localparam int unsigned WR_MAX  = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
    localparam int unsigned CNT_MAX = (RST_MAX > WR_MAX) ? RST_MAX : WR_MAX;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_RST_LOW,
        S_RST_WAIT,
        S_IDLE,
        S_WR_LO,
        S_WR_HI
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [16:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [16:0]       head;
    logic              push, pop;
    logic [LW-1:0]     level_d;
    logic              csx_d, wrx_d, dcx_d;
    logic [15:0]       d_d;
    logic              active_d;

    assign head    = mem[rd_ptr];
    // A word offered alongside hw_reset_req is dropped with the flush.
    assign push    = in_valid && in_ready && !hw_reset_req;
    assign cnt_inc = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + CW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RST_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, FIFO pop and next values of the panel strobes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        csx_d   = csx;
        wrx_d   = wrx;
        dcx_d   = dcx;
        d_d     = d;
        unique case (state_q)
            S_RST_LOW: begin
                if (cnt_q == CW'(RST_LOW_CYCLES - 1)) begin
                    state_d = S_RST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RST_WAIT: begin
                if (cnt_q == CW'(RST_WAIT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_IDLE: begin
                csx_d = 1'b1;
                wrx_d = 1'b1;
                if (fifo_level != '0) begin
                    pop     = 1'b1;
                    state_d = S_WR_LO;
                    cnt_d   = '0;
                    csx_d   = 1'b0;
                    wrx_d   = 1'b0;
                    dcx_d   = head[16];
                    d_d     = head[15:0];
                end
            end
            S_WR_LO: begin
                if (cnt_q == CW'(WR_LOW - 1)) begin
                    state_d = S_WR_HI;
                    cnt_d   = '0;
                    wrx_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WR_HI: begin
                if (cnt_q == CW'(WR_HIGH - 1)) begin
                    cnt_d = '0;
                    if (fifo_level != '0) begin
                        // Back-to-back: keep csx low and start the next word
                        pop     = 1'b1;
                        state_d = S_WR_LO;
                        wrx_d   = 1'b0;
                        dcx_d   = head[16];
                        d_d     = head[15:0];
                    end else begin
                        state_d = S_IDLE;
                        csx_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_RST_LOW;
                cnt_d   = '0;
            end
        endcase
        if (hw_reset_req) begin
            state_d = S_RST_LOW;
            cnt_d   = '0;
            pop     = 1'b0;
            csx_d   = 1'b1;
            wrx_d   = 1'b1;
        end
    end

    // FIFO occupancy after this edge
    always_comb begin
        level_d = fifo_level;
        if (hw_reset_req)
            level_d = '0;
        else if (push && !pop)
            level_d = fifo_level + LW'(1);
        else if (!push && pop)
            level_d = fifo_level - LW'(1);
    end

    assign active_d = (state_d == S_IDLE) || (state_d == S_WR_LO) || (state_d == S_WR_HI);

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_dcx, in_data};
    end

    // Pointers, status and registered panel outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            res_n      <= 1'b0;
            csx        <= 1'b1;
            wrx        <= 1'b1;
            rdx        <= 1'b1;
            dcx        <= 1'b1;
            d          <= '0;
            lcd_on     <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
        end else begin
            if (hw_reset_req) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_level <= level_d;
            res_n      <= (state_d != S_RST_LOW);
            csx        <= csx_d;
            wrx        <= wrx_d;
            rdx        <= 1'b1;
            dcx        <= dcx_d;
            d          <= d_d;
            lcd_on     <= lcd_on_en;
            in_ready   <= active_d && (level_d != LW'(FIFO_DEPTH));
            busy       <= (state_d != S_IDLE) || (level_d != '0);
        end
    end

endmodule

// File: tb/tb_lcd_8080_tx.sv
`timescale 1ns/1ps
// Testbench for lcd_8080_tx: table-driven timing vectors plus a panel-side
// capture model (latches {dcx,d} on wrx rising while csx low) checked against
// a queue of accepted words.
module tb_lcd_8080_tx;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WL    = 2;
    localparam int unsigned WH    = 2;
    localparam int unsigned RL    = 4;
    localparam int unsigned RW    = 8;
    localparam int          PER   = WL + WH;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_dcx, hw_reset_req, lcd_on_en;
    logic [15:0] in_data, d;
    logic        busy, res_n, csx, wrx, rdx, dcx, lcd_on;
    logic [4:0]  fifo_level;

    lcd_8080_tx #(
        .FIFO_DEPTH(DEPTH), .WR_LOW(WL), .WR_HIGH(WH),
        .RST_LOW_CYCLES(RL), .RST_WAIT_CYCLES(RW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dcx(in_dcx),
        .hw_reset_req(hw_reset_req), .lcd_on_en(lcd_on_en),
        .busy(busy), .fifo_level(fifo_level),
        .res_n(res_n), .csx(csx), .wrx(wrx), .rdx(rdx), .dcx(dcx), .d(d), .lcd_on(lcd_on)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [16:0] exp_q[$];
    int          cap_cyc[$];
    int          cyc = 0;
    int          n_cap = 0;
    int          saw_full = 0;
    logic        lcd_exp = 1'b0;
    logic        mon_en = 1'b0;
    logic        wrx_p = 1'b1, csx_p = 1'b1, dcx_p = 1'b1;
    logic [15:0] d_p = '0;
    logic        burst_win = 1'b0;
    int          burst_base = 0;
    int          burst_csx_hi = 0;

    // Accepted words enter the expected queue in order; any reset drops them all.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        lcd_exp <= reset ? 1'b0 : lcd_on_en;
        if (reset || hw_reset_req)
            exp_q.delete();
        else if (in_valid && in_ready)
            exp_q.push_back({in_dcx, in_data});
    end

    // Panel-side observer
    always @(negedge clk) begin
        if (mon_en) begin
            chk("rdx_const", rdx, 1);
            chk("lcd_on_follow", lcd_on, lcd_exp);
            if (fifo_level == 5'(DEPTH)) begin
                saw_full++;
                chk("full_in_ready", in_ready, 0);
            end
            if (!csx && !csx_p && !(wrx_p && !wrx)) begin
                chk("d_stable", d, d_p);
                chk("dcx_stable", dcx, dcx_p);
            end
            if (wrx && !wrx_p && !csx) begin
                n_cap++;
                cap_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL capture_unexpected: got %0h expected none", {dcx, d});
                end else begin
                    chk("capture", {15'd0, dcx, d}, {15'd0, exp_q.pop_front()});
                end
            end
            if (burst_win && csx && n_cap > burst_base && n_cap < burst_base + 16)
                burst_csx_hi++;
        end
        wrx_p = wrx;
        csx_p = csx;
        dcx_p = dcx;
        d_p   = d;
    end

    // ---------------- stimulus helpers ----------------
    logic [15:0] wd   [64];
    logic        wdcx [64];

    task automatic send_words(input int n, input bit toggle_lcd);
        int i;
        int guard;
        bit acc;
        i = 0;
        guard = 0;
        in_valid = 1'b1;
        in_data  = wd[0];
        in_dcx   = wdcx[0];
        while (i < n && guard < 5000) begin
            acc = in_ready;
            @(negedge clk);
            guard++;
            if (acc) begin
                i++;
                if (i < n) begin
                    in_data = wd[i];
                    in_dcx  = wdcx[i];
                end
            end
            if (toggle_lcd && ($urandom_range(0, 3) == 0))
                lcd_on_en = ~lcd_on_en;
        end
        in_valid = 1'b0;
        chk("send_done", i, n);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("drain_timeout", busy, 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic chk_gaps(input int base, input int n);
        if (cap_cyc.size() >= base + n)
            for (int i = 1; i < n; i++)
                chk("wr_period", cap_cyc[base+i] - cap_cyc[base+i-1], PER);
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic res_n;
        logic in_ready;
        logic busy;
    } pu_vec_t;

    typedef struct {
        logic        csx;
        logic        wrx;
        logic        chk_d;
        logic [15:0] d;
        logic        dcx;
        logic        busy;
        logic [4:0]  level;
    } wr_vec_t;

    pu_vec_t pu_tab [14];
    wr_vec_t wr_tab [6];

    initial begin
        int base;
        int pre;
        int lo_seen;

        // Power-up: res_n low RL cycles, then RW cycles of wait, then ready.
        for (int k = 0; k < 14; k++) begin
            pu_tab[k].res_n    = (k >= int'(RL));
            pu_tab[k].in_ready = (k >= int'(RL + RW));
            pu_tab[k].busy     = (k < int'(RL + RW));
        end
        // Single command 0x002C pushed on edge N; entry j sampled after edge N+j.
        wr_tab[0] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd1};
        wr_tab[1] = '{1'b0, 1'b0, 1'b1, 16'h002C, 1'b0, 1'b1, 5'd0};
        wr_tab[2] = '{1'b0, 1'b0, 1'b1, 16'h002C, 1'b0, 1'b1, 5'd0};
        wr_tab[3] = '{1'b0, 1'b1, 1'b1, 16'h002C, 1'b0, 1'b1, 5'd0};
        wr_tab[4] = '{1'b0, 1'b1, 1'b1, 16'h002C, 1'b0, 1'b1, 5'd0};
        wr_tab[5] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0};

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_dcx = 1'b0;
        hw_reset_req = 1'b0;
        lcd_on_en = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_res_n", res_n, 0);
        chk("rst_csx", csx, 1);
        chk("rst_wrx", wrx, 1);
        chk("rst_dcx", dcx, 1);
        chk("rst_d", d, 0);
        chk("rst_lcd_on", lcd_on, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_level", fifo_level, 0);
        mon_en = 1'b1;

        // Power-up sequence
        reset = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge clk);
            chk("pu_res_n", res_n, pu_tab[k].res_n);
            chk("pu_in_ready", in_ready, pu_tab[k].in_ready);
            chk("pu_busy", busy, pu_tab[k].busy);
            chk("pu_csx", csx, 1);
            chk("pu_wrx", wrx, 1);
        end

        // Single command write timing
        in_valid = 1'b1;
        in_data  = 16'h002C;
        in_dcx   = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("cmd_csx", csx, wr_tab[j].csx);
            chk("cmd_wrx", wrx, wr_tab[j].wrx);
            chk("cmd_busy", busy, wr_tab[j].busy);
            chk("cmd_level", fifo_level, wr_tab[j].level);
            if (wr_tab[j].chk_d) begin
                chk("cmd_d", d, wr_tab[j].d);
                chk("cmd_dcx", dcx, wr_tab[j].dcx);
            end
        end
        chk("cmd_captured", n_cap, 1);

        // Burst of 16 pixels
        for (int i = 0; i < 16; i++) begin
            wd[i]   = 16'hF800 + 16'(i);
            wdcx[i] = 1'b1;
        end
        base = n_cap;
        burst_base = n_cap;
        burst_win = 1'b1;
        send_words(16, 1'b0);
        wait_idle();
        burst_win = 1'b0;
        chk("burst_count", n_cap - base, 16);
        chk("burst_csx_low", burst_csx_hi, 0);
        chk_gaps(base, 16);

        // 64 random words through a full FIFO, lcd_on_en toggling
        for (int i = 0; i < 64; i++) begin
            wd[i]   = 16'($urandom);
            wdcx[i] = 1'($urandom_range(0, 1));
        end
        base = n_cap;
        send_words(64, 1'b1);
        wait_idle();
        chk("rand_count", n_cap - base, 64);
        chk("rand_saw_full", (saw_full > 0), 1);
        chk_gaps(base, 64);

        // hw_reset_req mid-burst
        for (int i = 0; i < 32; i++) begin
            wd[i]   = 16'($urandom);
            wdcx[i] = 1'($urandom_range(0, 1));
        end
        begin
            int i;
            int guard;
            bit acc;
            i = 0;
            guard = 0;
            in_valid = 1'b1;
            in_data  = wd[0];
            in_dcx   = wdcx[0];
            while (!(fifo_level >= 5'd7 && !wrx && !csx) && guard < 500 && i < 31) begin
                acc = in_ready;
                @(negedge clk);
                guard++;
                if (acc) begin
                    i++;
                    in_data = wd[i];
                    in_dcx  = wdcx[i];
                end
            end
            chk("hwr_reached_level", (fifo_level >= 5'd7 && !wrx), 1);
        end
        pre = n_cap;
        hw_reset_req = 1'b1;
        @(negedge clk);
        hw_reset_req = 1'b0;
        in_valid = 1'b0;
        chk("hwr_wrx", wrx, 1);
        chk("hwr_csx", csx, 1);
        chk("hwr_res_n", res_n, 0);
        chk("hwr_level", fifo_level, 0);
        chk("hwr_in_ready", in_ready, 0);
        lo_seen = 0;
        for (int k = 1; k <= int'(RL + RW); k++) begin
            @(negedge clk);
            if (!wrx || !csx) lo_seen++;
            if (k == int'(RL)) chk("hwr_res_n_rise", res_n, 1);
            if (k == int'(RL + RW) - 1) chk("hwr_ready_wait", in_ready, 0);
        end
        chk("hwr_no_strobe", lo_seen, 0);
        chk("hwr_ready_after", in_ready, 1);
        repeat (6) @(negedge clk);
        chk("hwr_no_write", n_cap, pre);
        chk("hwr_busy", busy, 0);
        chk("hwr_queue", exp_q.size(), 0);

        // Traffic resumes after the panel reset
        wd[0] = 16'h0029;
        wdcx[0] = 1'b0;
        send_words(1, 1'b0);
        wait_idle();
        chk("post_hwr_write", n_cap, pre + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
